// File: rtl/fft_out_reorder.sv
// Collects bit-reversed 4-lane FFT output frames in a ping-pong register buffer
// and re-emits them in natural bin order, four bins per cycle.
module fft_out_reorder #(
    parameter int NBITS = 15,
    parameter int N     = 128,
    parameter int LOG2N = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [2*NBITS-1:0]   in0_up,
    input  logic [2*NBITS-1:0]   in0_down,
    input  logic [2*NBITS-1:0]   in1_up,
    input  logic [2*NBITS-1:0]   in1_down,
    output logic                 out_valid,
    output logic                 out_sof,
    output logic [2*NBITS-1:0]   out0,
    output logic [2*NBITS-1:0]   out1,
    output logic [2*NBITS-1:0]   out2,
    output logic [2*NBITS-1:0]   out3,
    output logic                 frame_done
);
    localparam int W  = 2 * NBITS;
    localparam int CW = LOG2N - 2;
    localparam logic [CW-1:0] LAST = CW'(N / 4 - 1);

    typedef enum logic {IDLE, READ} state_t;

    // Handshake: in_valid/out_valid are pure qualifiers; there is no ready in either
    // direction, so every valid input beat is consumed and every output beat is final.
    state_t         state, state_nxt;
    logic [W-1:0]   mem [2][N];
    logic [W-1:0]   lane [4];
    logic [CW-1:0]  wcnt, rcnt;
    logic           wbank, rbank;
    logic [1:0]     full, full_nxt;
    logic           wlast, rlast;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] k);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = k[LOG2N-1-i];
        return r;
    endfunction

    assign lane[0] = in0_up;
    assign lane[1] = in0_down;
    assign lane[2] = in1_up;
    assign lane[3] = in1_down;

    assign wlast = in_valid && (wcnt == LAST);
    assign rlast = (state == READ) && (rcnt == LAST);

    // Storage is deliberately not reset; only the bookkeeping around it is.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            for (int l = 0; l < 4; l++) begin
                mem[wbank][bitrev({wcnt, l[1:0]})] <= lane[l];
            end
        end
    end

    // A completion into a bank that is still full is dropped: its flag stays put.
    always_comb begin
        full_nxt = full;
        if (rlast) full_nxt[rbank] = 1'b0;
        if (wlast && !full[wbank]) full_nxt[wbank] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt  <= '0;
            wbank <= 1'b0;
            full  <= 2'b00;
        end else begin
            full <= full_nxt;
            if (in_valid) wcnt <= wcnt + 1'b1;
            if (wlast && !full[wbank]) wbank <= ~wbank;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Banks are consumed alternately, so the next bank to read is always ~rbank.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (full[rbank]) state_nxt = READ;
            READ:    if (rlast && !full[~rbank]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt       <= '0;
            rbank      <= 1'b0;
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            frame_done <= 1'b0;
            out0       <= '0;
            out1       <= '0;
            out2       <= '0;
            out3       <= '0;
        end else if (state == READ) begin
            out0       <= mem[rbank][{rcnt, 2'd0}];
            out1       <= mem[rbank][{rcnt, 2'd1}];
            out2       <= mem[rbank][{rcnt, 2'd2}];
            out3       <= mem[rbank][{rcnt, 2'd3}];
            out_valid  <= 1'b1;
            out_sof    <= (rcnt == '0);
            frame_done <= rlast;
            rcnt       <= rcnt + 1'b1;
            if (rlast) rbank <= ~rbank;
        end else begin
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            frame_done <= 1'b0;
        end
    end

    overflow_check: assert property (@(posedge clk) disable iff (rst) !(wlast && full[wbank]));

endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed scoreboard bench for fft_out_reorder at N=16: reorder, latency,
// back-to-back frames, gapped input, reset mid-frame and full-scale data.
module tb_fft_out_reorder;
    localparam int NBITS = 15;
    localparam int N     = 16;
    localparam int LOG2N = 4;
    localparam int W     = 2 * NBITS;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in0_up, in0_down, in1_up, in1_down;
    logic         out_valid, out_sof, frame_done;
    logic [W-1:0] out0, out1, out2, out3;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    logic [4*W+1:0] exp_q[$];
    int             cyc_q[$];

    // Sequence index k that holds natural bin b (4-bit bit reversal, by hand).
    int br_tab [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    fft_out_reorder #(.NBITS(NBITS), .N(N), .LOG2N(LOG2N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .in0_up(in0_up), .in0_down(in0_down), .in1_up(in1_up), .in1_down(in1_down),
        .out_valid(out_valid), .out_sof(out_sof),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .frame_done(frame_done)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [W-1:0] sample(input int mode, input int tag, input int k);
        logic [NBITS-1:0] re, im;
        case (mode)
            0: begin re = 15'(k); im = 15'(-k); end
            1: begin re = 15'(37 * tag + k); im = 15'(-(200 + 3 * k + tag)); end
            default: begin
                re = k[0] ? 15'h4000 : 15'h3FFF;
                im = k[0] ? 15'h3FFF : 15'h4000;
            end
        endcase
        return {re, im};
    endfunction

    // driver: nb beats of a frame; a full frame pushes its expected output beats
    task automatic send_frame(input int mode, input int tag, input int gap, input int nb);
        int e;
        logic [W-1:0] s [4];
        e = 0;
        for (int c = 0; c < nb; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in0_up   = sample(mode, tag, 4 * c + 0);
            in0_down = sample(mode, tag, 4 * c + 1);
            in1_up   = sample(mode, tag, 4 * c + 2);
            in1_down = sample(mode, tag, 4 * c + 3);
            if (c == nb - 1) e = cyc + 1;
            if (gap != 0) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
        end
        if (nb == 4) begin
            for (int c = 0; c < 4; c++) begin
                for (int j = 0; j < 4; j++) s[j] = sample(mode, tag, br_tab[4 * c + j]);
                exp_q.push_back({(c == 0), (c == 3), s[0], s[1], s[2], s[3]});
                cyc_q.push_back(e + 2 + c);
            end
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clk);
        check("drain_queue_empty", 128'(exp_q.size()), 128'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 128'(out_valid), 128'd0);
        check({tag, "_out_sof"}, 128'(out_sof), 128'd0);
        check({tag, "_frame_done"}, 128'(frame_done), 128'd0);
        check({tag, "_data"}, 128'({out0, out1, out2, out3}), 128'd0);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [4*W+1:0] v;
        int ec;
        if (!rst) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_beat: got out_valid=1 expected no beat (cycle %0d)", cyc);
                end else begin
                    v  = exp_q.pop_front();
                    ec = cyc_q.pop_front();
                    check("beat", 128'({out_sof, frame_done, out0, out1, out2, out3}), 128'(v));
                    check("beat_cycle", 128'(cyc), 128'(ec));
                end
            end else begin
                check("idle_flags", 128'({out_sof, frame_done}), 128'd0);
            end
        end
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in0_up = '0; in0_down = '0; in1_up = '0; in1_down = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        #2 rst = 1'b0;

        // reorder and E+2 latency
        send_frame(0, 0, 0, 4);
        idle();
        drain();

        // three back-to-back frames: 12 consecutive beats at exact cycles
        send_frame(1, 1, 0, 4);
        send_frame(1, 2, 0, 4);
        send_frame(1, 3, 0, 4);
        idle();
        drain();

        // gapped input 1010...
        send_frame(0, 0, 1, 4);
        drain();

        // full-scale sign bits
        send_frame(2, 0, 0, 4);
        idle();
        drain();

        // reset while frame A is being output and frame B is half written
        send_frame(1, 4, 0, 4);
        send_frame(1, 9, 0, 2);
        @(negedge clk);
        #2;
        rst = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        cyc_q.delete();
        #1 check_reset_outputs("async_rst");
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs("in_rst");
        end
        #2 rst = 1'b0;
        send_frame(1, 5, 0, 4);
        idle();
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish before 20000");
        $fatal(1, "timeout");
    end

endmodule
